// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: memorises the LED moves the game shows, replays them on
// the buttons, then presses a new rotating move when the game asks for one.
module jogador_automatico #(
    parameter int unsigned N_MAX        = 16,
    parameter int unsigned PRESS_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     habilita,
    input  logic [3:0]               leds,
    input  logic                     vez_jogador,
    input  logic                     vez_adicionar,
    output logic [3:0]               botoes,
    output logic                     ocupado,
    output logic                     erro,
    output logic [$clog2(N_MAX):0]   db_tamanho,
    output logic [3:0]               db_estado
);

    localparam int unsigned PW   = $clog2(N_MAX) + 1;
    localparam int unsigned AW   = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int unsigned TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    localparam logic [3:0] OCIOSO         = 4'd0;
    localparam logic [3:0] OUVINDO        = 4'd1;
    localparam logic [3:0] PREPARA        = 4'd2;
    localparam logic [3:0] PRESSIONA      = 4'd3;
    localparam logic [3:0] SOLTA          = 4'd4;
    localparam logic [3:0] AGUARDA_ADD    = 4'd5;
    localparam logic [3:0] PRESSIONA_NOVO = 4'd6;
    localparam logic [3:0] SOLTA_NOVO     = 4'd7;
    localparam logic [3:0] ERRO           = 4'd8;

    logic [3:0]    estado, estado_prox;
    logic [PW-1:0] wr, wr_prox;
    logic [PW-1:0] rd, rd_prox;
    logic [TW-1:0] timer, timer_prox;
    logic [3:0]    novo, novo_prox;
    logic [3:0]    botao_reg, botao_prox;
    logic [3:0]    leds_prev;
    logic [3:0]    botoes_prox;
    logic          subida;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [3:0]    mem [N_MAX];

    assign subida     = (leds != 4'd0) && (leds_prev == 4'd0);
    assign db_tamanho = wr;
    assign db_estado  = estado;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            wr        <= '0;
            rd        <= '0;
            timer     <= '0;
            novo      <= 4'b0001;
            botao_reg <= 4'd0;
            leds_prev <= 4'd0;
            botoes    <= 4'd0;
            ocupado   <= 1'b0;
            erro      <= 1'b0;
        end else begin
            estado    <= estado_prox;
            wr        <= wr_prox;
            rd        <= rd_prox;
            timer     <= timer_prox;
            novo      <= novo_prox;
            botao_reg <= botao_prox;
            leds_prev <= leds;
            botoes    <= botoes_prox;
            ocupado   <= (estado_prox == PREPARA) || (estado_prox == PRESSIONA) ||
                         (estado_prox == SOLTA) || (estado_prox == PRESSIONA_NOVO) ||
                         (estado_prox == SOLTA_NOVO);
            erro      <= (estado_prox == ERRO);
        end
    end

    // Move memory: contents are only meaningful below wr, so no reset
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_wa] <= leds;
    end

    // Next-state, datapath and button decode
    always_comb begin
        estado_prox = estado;
        wr_prox     = wr;
        rd_prox     = rd;
        timer_prox  = timer;
        novo_prox   = novo;
        botao_prox  = botao_reg;
        mem_we      = 1'b0;
        mem_wa      = wr[AW-1:0];
        botoes_prox = 4'd0;

        if (!habilita) begin
            estado_prox = OCIOSO;
            wr_prox     = '0;
        end else begin
            case (estado)
                OCIOSO: estado_prox = OUVINDO;
                OUVINDO: begin
                    if (subida) begin
                        if (wr == PW'(N_MAX)) begin
                            estado_prox = ERRO;
                        end else begin
                            mem_we  = 1'b1;
                            wr_prox = wr + PW'(1);
                        end
                    end else if (vez_jogador && (leds == 4'd0)) begin
                        if (wr == '0) begin
                            estado_prox = ERRO;
                        end else begin
                            rd_prox     = '0;
                            estado_prox = PREPARA;
                        end
                    end
                end
                PREPARA: begin
                    botao_prox  = mem[rd[AW-1:0]];
                    timer_prox  = TW'(PRESS_CYCLES - 1);
                    estado_prox = PRESSIONA;
                end
                PRESSIONA: begin
                    botoes_prox = botao_reg;
                    if (timer == '0) begin
                        timer_prox  = TW'(GAP_CYCLES - 1);
                        estado_prox = SOLTA;
                    end else begin
                        timer_prox = timer - TW'(1);
                    end
                end
                SOLTA: begin
                    if (timer == '0) begin
                        if (rd == wr - PW'(1)) begin
                            estado_prox = AGUARDA_ADD;
                        end else begin
                            rd_prox     = rd + PW'(1);
                            estado_prox = PREPARA;
                        end
                    end else begin
                        timer_prox = timer - TW'(1);
                    end
                end
                AGUARDA_ADD: begin
                    if (vez_adicionar) begin
                        timer_prox  = TW'(PRESS_CYCLES - 1);
                        estado_prox = PRESSIONA_NOVO;
                    end else if (subida) begin
                        // Game restarted its display: start memorising from this LED
                        mem_we      = 1'b1;
                        mem_wa      = '0;
                        wr_prox     = PW'(1);
                        estado_prox = OUVINDO;
                    end
                end
                PRESSIONA_NOVO: begin
                    botoes_prox = novo;
                    if (timer == '0) begin
                        timer_prox  = TW'(GAP_CYCLES - 1);
                        estado_prox = SOLTA_NOVO;
                    end else begin
                        timer_prox = timer - TW'(1);
                    end
                end
                SOLTA_NOVO: begin
                    if (timer == '0) begin
                        novo_prox   = {novo[2:0], novo[3]};
                        wr_prox     = '0;
                        estado_prox = OUVINDO;
                    end else begin
                        timer_prox = timer - TW'(1);
                    end
                end
                ERRO: estado_prox = ERRO;
                default: estado_prox = OCIOSO;
            endcase
        end
    end

endmodule
